// File: rtl/super_pixel_readout_arbiter.sv
// Super pixel readout arbiter: round-robin capture of pixel hits into a local
// FIFO, merged fairly with the upstream column daisy-chain onto one stream.

module super_pixel_readout_lane #(
  parameter int TOA_W  = 9,
  parameter int FTOA_W = 5,
  parameter int TOT_W  = 8,
  parameter int ADDR_W = 3,
  parameter int IDX    = 0,
  parameter int DATA_W = TOA_W + FTOA_W + TOT_W + ADDR_W + 1
) (
  input  logic              req,
  input  logic              ack,
  input  logic [TOA_W-1:0]  toa,
  input  logic [FTOA_W-1:0] ftoa,
  input  logic [TOT_W-1:0]  tot,
  input  logic              addr_col,
  output logic              elig,
  output logic [DATA_W-1:0] word
);
  // The pixel being acked this cycle still shows req; mask it so it can drop.
  assign elig = req && !ack;
  assign word = {toa, ftoa, tot, ADDR_W'(IDX), addr_col};
endmodule

module super_pixel_readout_arbiter #(
  parameter int N_PIX      = 8,
  parameter int TOA_W      = 9,
  parameter int FTOA_W     = 5,
  parameter int TOT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(N_PIX),
  parameter int DATA_W     = TOA_W + FTOA_W + TOT_W + ADDR_W + 1
) (
  input  logic                            clk_40MHz,
  input  logic                            rst_n,
  input  logic                            shutter,
  input  logic                            addr_col,
  input  logic [N_PIX-1:0]                pix_req,
  input  logic [N_PIX*TOA_W-1:0]          pix_toa,
  input  logic [N_PIX*FTOA_W-1:0]         pix_ftoa,
  input  logic [N_PIX*TOT_W-1:0]          pix_tot,
  output logic [N_PIX-1:0]                pix_ack,
  input  logic [DATA_W-1:0]               last_data,
  input  logic                            last_valid,
  output logic                            shake_hands_last,
  input  logic                            shake_hands_next,
  output logic [DATA_W-1:0]               arbiter_data,
  output logic                            data_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   NPIX_C   = (ADDR_W+1)'(N_PIX);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [LVL_W-1:0]  DEPTH_C  = LVL_W'(FIFO_DEPTH);

  logic [N_PIX-1:0]             elig;
  logic [N_PIX-1:0][DATA_W-1:0] lane_word;

  for (genvar i = 0; i < N_PIX; i++) begin : g_lane
    super_pixel_readout_lane #(
      .TOA_W(TOA_W), .FTOA_W(FTOA_W), .TOT_W(TOT_W),
      .ADDR_W(ADDR_W), .IDX(i), .DATA_W(DATA_W)
    ) u_lane (
      .req      (pix_req[i]),
      .ack      (pix_ack[i]),
      .toa      (pix_toa[i*TOA_W +: TOA_W]),
      .ftoa     (pix_ftoa[i*FTOA_W +: FTOA_W]),
      .tot      (pix_tot[i*TOT_W +: TOT_W]),
      .addr_col (addr_col),
      .elig     (elig[i]),
      .word     (lane_word[i])
    );
  end

  logic [ADDR_W-1:0] rr;
  logic [ADDR_W-1:0] grant_idx;
  logic              grant_any;
  logic              push;
  logic [ADDR_W:0]   sum;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, empty, pop;

  assign full  = (fifo_level == DEPTH_C);
  assign empty = (fifo_level == '0);

  // Rotating priority search starting at rr, wrapping modulo N_PIX.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < N_PIX; k++) begin
      sum = {1'b0, rr} + (ADDR_W+1)'(k);
      if (sum >= NPIX_C) sum = sum - NPIX_C;
      if (!grant_any && elig[sum[ADDR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[ADDR_W-1:0];
      end
    end
  end

  // Full blocks the push even when a pop frees a slot this same cycle.
  assign push = grant_any && shutter && !full;

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= '0;
      pix_ack <= '0;
    end else begin
      pix_ack <= '0;
      if (push) begin
        pix_ack[grant_idx] <= 1'b1;
        rr <= (grant_idx == LAST_PIX) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (push) mem[wr_ptr] <= lane_word[grant_idx];
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output stage: pri toggles away from whichever source was last served.
  logic load, pri, sel_up, sel_local;

  assign load      = !data_valid || shake_hands_next;
  assign sel_up    = last_valid && (empty || pri);
  assign sel_local = !empty && !sel_up;
  assign pop       = load && sel_local;
  assign shake_hands_last = load && sel_up;

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      arbiter_data <= '0;
      data_valid   <= 1'b0;
      pri          <= 1'b0;
    end else if (load) begin
      if (sel_up || sel_local) begin
        arbiter_data <= sel_up ? last_data : mem[rd_ptr];
        data_valid   <= 1'b1;
        pri          <= sel_local;
      end else begin
        data_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_super_pixel_readout_arbiter.sv
// Directed bench for super_pixel_readout_arbiter at default parameters.

module tb_super_pixel_readout_arbiter;
  localparam int N_PIX  = 8;
  localparam int DATA_W = 26;

  logic              clk_40MHz = 1'b0;
  logic              rst_n;
  logic              shutter;
  logic              addr_col;
  logic [7:0]        pix_req;
  logic [71:0]       pix_toa;
  logic [39:0]       pix_ftoa;
  logic [63:0]       pix_tot;
  logic [7:0]        pix_ack;
  logic [25:0]       last_data;
  logic              last_valid;
  logic              shake_hands_last;
  logic              shake_hands_next;
  logic [25:0]       arbiter_data;
  logic              data_valid;
  logic [2:0]        fifo_level;

  super_pixel_readout_arbiter dut (
    .clk_40MHz(clk_40MHz), .rst_n(rst_n), .shutter(shutter), .addr_col(addr_col),
    .pix_req(pix_req), .pix_toa(pix_toa), .pix_ftoa(pix_ftoa), .pix_tot(pix_tot),
    .pix_ack(pix_ack), .last_data(last_data), .last_valid(last_valid),
    .shake_hands_last(shake_hands_last), .shake_hands_next(shake_hands_next),
    .arbiter_data(arbiter_data), .data_valid(data_valid), .fifo_level(fifo_level)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  int checks = 0;
  int failures = 0;
  int ack_cnt [N_PIX];
  int shl_cnt, up_idx, up_lim, max_lvl;
  logic [25:0] out_q [$];

  function automatic logic [25:0] up_word(input int k);
    return 26'h2A00000 + 26'(k * 7 + 3);
  endfunction

  function automatic logic [25:0] pix_word(input int i, input logic col);
    logic [8:0] toa;
    logic [4:0] ftoa;
    logic [7:0] tot;
    toa  = 9'h10 + 9'(i);
    ftoa = 5'(i + 1);
    tot  = 8'h80 + 8'(i);
    return {toa, ftoa, tot, 3'(i), col};
  endfunction

  task automatic set_pix_data();
    for (int i = 0; i < N_PIX; i++) begin
      pix_toa[i*9 +: 9]  = 9'h10 + 9'(i);
      pix_ftoa[i*5 +: 5] = 5'(i + 1);
      pix_tot[i*8 +: 8]  = 8'h80 + 8'(i);
    end
  endtask

  // One clock: observe transfers/handshakes before the edge, then model pixels.
  task automatic tick();
    logic shl_now;
    @(negedge clk_40MHz);
    if (data_valid && shake_hands_next) out_q.push_back(arbiter_data);
    shl_now = shake_hands_last;
    if (shl_now) shl_cnt++;
    @(posedge clk_40MHz);
    #1;
    for (int i = 0; i < N_PIX; i++)
      if (pix_ack[i]) begin
        ack_cnt[i]++;
        pix_req[i] = 1'b0;
      end
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (shl_now) begin
      up_idx++;
      last_data = up_word(up_idx);
      if (up_idx >= up_lim) last_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_req = '0;
    last_valid = 1'b0;
    last_data = '0;
    shake_hands_next = 1'b0;
    shutter = 1'b1;
    addr_col = 1'b0;
    set_pix_data();
    #12;
    @(negedge clk_40MHz);
    rst_n = 1'b1;
    @(posedge clk_40MHz);
    #1;
    for (int i = 0; i < N_PIX; i++) ack_cnt[i] = 0;
    shl_cnt = 0; up_idx = 0; up_lim = 0; max_lvl = 0;
    out_q.delete();
  endtask

  function automatic int total_acks();
    int s = 0;
    for (int i = 0; i < N_PIX; i++) s += ack_cnt[i];
    return s;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (arbiter_data !== 26'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", arbiter_data); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (pix_ack !== 8'h00) begin failures++; $display("FAIL reset_ack got=%h exp=00", pix_ack); end
    checks++; if (shake_hands_last !== 1'b0) begin failures++; $display("FAIL reset_shl got=%b exp=0", shake_hands_last); end
  endtask

  task automatic test_single_hit();
    do_reset();
    pix_toa[8:0] = 9'h1FF;
    pix_ftoa[4:0] = 5'd5;
    pix_tot[7:0] = 8'd16;
    shake_hands_next = 1'b1;
    pix_req[0] = 1'b1;
    tick();
    checks++; if (pix_ack !== 8'h01) begin failures++; $display("FAIL hit_ack got=%h exp=01", pix_ack); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL hit_level1 got=%0d exp=1", fifo_level); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL hit_early_valid got=%b exp=0", data_valid); end
    tick();
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL hit_valid got=%b exp=1", data_valid); end
    checks++; if (arbiter_data !== 26'h3FE5100) begin failures++; $display("FAIL hit_word got=%h exp=3fe5100", arbiter_data); end
    checks++; if (pix_ack !== 8'h00) begin failures++; $display("FAIL hit_ack_pulse got=%h exp=00", pix_ack); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL hit_level0 got=%0d exp=0", fifo_level); end
    tick();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL hit_drain got=%b exp=0", data_valid); end
    checks++; if (ack_cnt[0] !== 1) begin failures++; $display("FAIL hit_ack_count got=%0d exp=1", ack_cnt[0]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    shake_hands_next = 1'b1;
    pix_req = 8'hFF;
    repeat (12) tick();
    checks++; if (out_q.size() !== 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < N_PIX && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== pix_word(i, 1'b0)) begin failures++; $display("FAIL rr_word[%0d] got=%h exp=%h", i, out_q[i], pix_word(i, 1'b0)); end
    end
    for (int i = 0; i < N_PIX; i++) begin
      checks++; if (ack_cnt[i] !== 1) begin failures++; $display("FAIL rr_ack[%0d] got=%0d exp=1", i, ack_cnt[i]); end
    end
    checks++; if (max_lvl > 1) begin failures++; $display("FAIL rr_max_level got=%0d exp<=1", max_lvl); end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    do_reset();
    up_lim = 1;
    last_data = up_word(0);
    last_valid = 1'b1;
    tick();
    checks++; if (shl_cnt !== 1) begin failures++; $display("FAIL bp_shl got=%0d exp=1", shl_cnt); end
    checks++; if (arbiter_data !== up_word(0)) begin failures++; $display("FAIL bp_first got=%h exp=%h", arbiter_data, up_word(0)); end
    pix_req = 8'hFF;
    repeat (8) begin
      tick();
      if (arbiter_data !== up_word(0) || data_valid !== 1'b1) unstable++;
    end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", unstable); end
    checks++; if (total_acks() !== 4) begin failures++; $display("FAIL bp_acks got=%0d exp=4", total_acks()); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    shake_hands_next = 1'b1;
    repeat (14) tick();
    checks++; if (total_acks() !== 8) begin failures++; $display("FAIL bp_acks_after got=%0d exp=8", total_acks()); end
    checks++; if (out_q.size() !== 9) begin failures++; $display("FAIL bp_count got=%0d exp=9", out_q.size()); end
    if (out_q.size() == 9) begin
      checks++; if (out_q[0] !== up_word(0)) begin failures++; $display("FAIL bp_word0 got=%h exp=%h", out_q[0], up_word(0)); end
      for (int i = 0; i < N_PIX; i++) begin
        checks++; if (out_q[i+1] !== pix_word(i, 1'b0)) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i+1, out_q[i+1], pix_word(i, 1'b0)); end
      end
    end
  endtask

  task automatic test_interleave();
    do_reset();
    shake_hands_next = 1'b1;
    addr_col = 1'b1;
    pix_req = 8'hFF;
    tick();
    up_lim = 8;
    last_data = up_word(0);
    last_valid = 1'b1;
    repeat (22) tick();
    checks++; if (out_q.size() !== 16) begin failures++; $display("FAIL il_count got=%0d exp=16", out_q.size()); end
    checks++; if (shl_cnt !== 8) begin failures++; $display("FAIL il_shl got=%0d exp=8", shl_cnt); end
    for (int i = 0; i < 8 && 2*i+1 < out_q.size(); i++) begin
      checks++; if (out_q[2*i] !== pix_word(i, 1'b1)) begin failures++; $display("FAIL il_local[%0d] got=%h exp=%h", i, out_q[2*i], pix_word(i, 1'b1)); end
      checks++; if (out_q[2*i+1] !== up_word(i)) begin failures++; $display("FAIL il_up[%0d] got=%h exp=%h", i, out_q[2*i+1], up_word(i)); end
    end
  endtask

  task automatic test_shutter();
    do_reset();
    shake_hands_next = 1'b1;
    shutter = 1'b0;
    pix_req[3] = 1'b1;
    repeat (10) tick();
    checks++; if (ack_cnt[3] !== 0) begin failures++; $display("FAIL sh_no_ack got=%0d exp=0", ack_cnt[3]); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL sh_level got=%0d exp=0", fifo_level); end
    shutter = 1'b1;
    tick();
    checks++; if (pix_ack !== 8'h08) begin failures++; $display("FAIL sh_ack got=%h exp=08", pix_ack); end
  endtask

  task automatic test_async_reset();
    do_reset();
    up_lim = 1;
    last_data = up_word(0);
    last_valid = 1'b1;
    pix_req = 8'h07;
    repeat (4) tick();
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL ar_pre_level got=%0d exp=3", fifo_level); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", data_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", data_valid); end
    checks++; if (arbiter_data !== 26'h0) begin failures++; $display("FAIL ar_data got=%h exp=0", arbiter_data); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL ar_level got=%0d exp=0", fifo_level); end
    checks++; if (pix_ack !== 8'h00) begin failures++; $display("FAIL ar_ack got=%h exp=00", pix_ack); end
    @(negedge clk_40MHz);
    rst_n = 1'b1;
    @(posedge clk_40MHz);
    #1;
    pix_req = 8'h22;
    tick();
    checks++; if (pix_ack !== 8'h02) begin failures++; $display("FAIL ar_rr_restart got=%h exp=02", pix_ack); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_round_robin();
    test_backpressure();
    test_interleave();
    test_shutter();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/super_pixel_readout_arbiter.md
# super_pixel_readout_arbiter

Parametrised readout arbiter for one super pixel. It takes completed hit events (TOA, FTOA, TOT) from N_PIX pixel front-ends and grants them round-robin into a local event FIFO. It merges that FIFO with the upstream column daisy-chain (last_data) and drives one valid/ready word stream (arbiter_data) toward the next super pixel or the column end. Compared with the fixed 8-pixel, 26-bit arbiter, it adds:
- configurable width, depth and pixel count;
- lossless back-pressure;
- fair local/upstream interleaving.

## Interface
Parameters:
- N_PIX, 8, pixels per super pixel (2..16)
- TOA_W, 9, coarse timestamp width
- FTOA_W, 5, fine TOA width (640 MHz phase count)
- TOT_W, 8, time-over-threshold width
- FIFO_DEPTH, 4, local event FIFO depth (power of 2, ≥2)
- ADDR_W, clog2(N_PIX), pixel address width (derived)
- DATA_W, TOA_W+FTOA_W+TOT_W+ADDR_W+1, word width (derived, 26 at defaults)

Ports:
- clk_40MHz  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- shutter  in  1  1 = new pixel grants enabled; 0 = no grants, drain continues
- addr_col  in  1  column address bit placed in word LSB
- pix_req  in  N_PIX  per-pixel event pending; level, held until acked
- pix_toa  in  N_PIX*TOA_W  flattened TOA, pixel i at [i*TOA_W +: TOA_W]
- pix_ftoa  in  N_PIX*FTOA_W  flattened FTOA, same packing
- pix_tot  in  N_PIX*TOT_W  flattened TOT, same packing
- pix_ack  out  N_PIX  one-cycle registered capture acknowledge
- last_data  in  DATA_W  upstream chain word
- last_valid  in  1  upstream word valid
- shake_hands_last  out  1  upstream word accepted this cycle (combinational)
- shake_hands_next  in  1  downstream ready
- arbiter_data  out  DATA_W  output word, registered
- data_valid  out  1  arbiter_data valid, registered
- fifo_level  out  clog2(FIFO_DEPTH+1)  local FIFO occupancy

## Operation
- Local word format, MSB→LSB: {TOA, FTOA, TOT, pixel index, addr_col}. Default layout is TOA[25:17], FTOA[16:12], TOT[11:4], addr[3:1], col[0].
- Upstream words pass through unmodified.

Capture stage, one grant per cycle:
- Eligible pixel: pix_req[i]=1 and pix_ack[i]=0. The pixel acked in the current cycle is masked, so the pixel has one cycle to drop its request.
- A grant requires shutter=1 and FIFO not full.
- Full blocks the push even if a pop occurs in the same cycle.
- Round-robin search starts at pointer rr and wraps modulo N_PIX. The first eligible pixel g is granted.
- On a grant: the word is written to the FIFO, pix_ack[g]=1 for the next cycle, and rr←(g+1) mod N_PIX.
- rr resets to 0.

Output stage:
- load = !data_valid || shake_hands_next.
- Candidates are the FIFO head (non-empty) and the upstream word (last_valid).
- If both are pending, toggle bit pri selects the source (0 = local, 1 = upstream). After serving a source, pri points to the other source.
- If one is pending, that source is served and pri is set to point away from it.
- On load with a candidate: arbiter_data←word and data_valid←1.
  - Local source: the FIFO pops.
  - Upstream source: shake_hands_last=1 in the same cycle.
- On load with no candidate: data_valid←0 and arbiter_data holds its last value.
- shake_hands_last=0 whenever upstream is not selected.
- A transfer occurs at an edge where data_valid=1 and shake_hands_next=1.

Reset (async, any time, including mid-transfer): FIFO emptied, rr=0, pri=0, pix_ack=0, data_valid=0, arbiter_data=0, fifo_level=0. Any in-flight word is discarded.

## Timing
- Request to data, FIFO empty and output free: pix_req is high before edge k. The FIFO write and pix_ack register happen at edge k, and pix_ack is high during cycle k..k+1. The FIFO pop and data_valid=1 happen at edge k+1. Total 2 cycles.
- Upstream to data: last_valid high, output free, upstream selected. shake_hands_last is high in the same cycle, and data_valid=1 after the next edge. Latency is 1 cycle.
- Full throughput: with shake_hands_next held high, one word per cycle. Local and upstream alternate when both sources are saturated.
- Back-pressure: with shake_hands_next=0 and data_valid=1, arbiter_data is stable. After FIFO_DEPTH further grants, the FIFO is full and pix_ack stays 0. No event is lost.
- fifo_level updates at the same edge as the push or pop.
- Simultaneous push and pop on a non-full FIFO leaves the level unchanged.

## Test plan
- Single hit: pixel 0 with TOA=0x1FF, FTOA=5, TOT=16, addr_col=0 → after 2 cycles data_valid=1 and arbiter_data={9'h1FF,5'd5,8'd16,3'd0,1'b0}, with pix_ack[0] pulsed 1 cycle.
- All 8 pix_req rise together, shake_hands_next=1 → pixel indices emerge 0,1,…,7 one per cycle. Each pix_ack fires once and fifo_level never exceeds 1.
- shake_hands_next=0 while 8 requests are pending → exactly 4 acks, fifo_level=4, arbiter_data stable. Release → the remaining 4 pixels are acked and all 9 words are delivered in order.
- last_valid held with local traffic saturated → outputs alternate local, upstream, local, and so on. shake_hands_last is high only in upstream cycles, and upstream words are unchanged.
- shutter=0 with pix_req[3]=1 → no ack for 10 cycles. After shutter=1, pixel 3 is acked next cycle.
- rst_n pulsed low asynchronously with FIFO at 3 words and data_valid=1 → all outputs are 0 immediately. After release, the first hit is captured with rr=0.
